// File: rtl/i2s_audio_pkg.sv
// Shared constants, types and the clock divider helper for the I2S audio transmitter.
package i2s_audio_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  typedef logic [5:0] bit_cnt_t;

  // Half-period of the bit clock in system clocks; 64 bck periods per frame.
  function automatic int calc_half(input int clk_rate, input int audio_rate);
    return clk_rate / (audio_rate * FRAME_BITS * 2);
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: divides clk down to i2s_bck and flags the clk cycle where bck falls.
module i2s_bck_gen #(
  parameter int HALF = 1
) (
  input  logic clk,
  input  logic reset,
  output logic bck_o,
  output logic fall_stb_o
);

  localparam int               DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic             bck_q;
  logic             wrap;

  assign wrap = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
    end else if (wrap) begin
      div_cnt_q <= '0;
      bck_q     <= ~bck_q;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  assign bck_o      = bck_q;
  // bck is high and about to toggle: this edge is the falling one.
  assign fall_stb_o = wrap & bck_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S master transmitter for the stereo mixer output; free-running bck/lrck, one sample pair per frame.
// Define I2S_AUDIO_TX_LJ_EN for left-justified framing instead of standard I2S.
module i2s_audio_tx
  import i2s_audio_pkg::*;
#(
  parameter int CLK_RATE   = 32000000,
  parameter int AUDIO_RATE = 48000,
  parameter int AUDIO_DW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AUDIO_DW-1:0] left_in,
  input  logic [AUDIO_DW-1:0] right_in,
  output logic                sample_req,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  localparam int         HALF = calc_half(CLK_RATE, AUDIO_RATE);
  localparam logic [5:0] DW6  = 6'(AUDIO_DW);

  if (HALF < 1) begin : g_half_chk
    $error("i2s_audio_tx: CLK_RATE too low for AUDIO_RATE (HALF < 1)");
  end
  if (AUDIO_DW < 1 || AUDIO_DW > SLOT_BITS) begin : g_dw_chk
    $error("i2s_audio_tx: AUDIO_DW must be 1..32");
  end

  logic                fall_stb;
  bit_cnt_t            bit_cnt_q, bit_cnt_d;
  logic [AUDIO_DW-1:0] lsh_q, lsh_d, rsh_q, rsh_d;
  logic [AUDIO_DW-1:0] word;
  logic                frame_wrap;
  logic [4:0]          pos;
  logic [5:0]          shamt;
  logic                bit_en, use_prev, prev_lsb, word_bit;
  logic                lrck_q, data_q, req_q, data_d;

  i2s_bck_gen #(.HALF(HALF)) u_bck_gen (
    .clk       (clk),
    .reset     (reset),
    .bck_o     (i2s_bck),
    .fall_stb_o(fall_stb)
  );

  always_comb begin
    bit_cnt_d  = bit_cnt_q + 6'd1;
    frame_wrap = (bit_cnt_q == bit_cnt_t'(FRAME_BITS - 1));
    lsh_d      = frame_wrap ? left_in  : lsh_q;
    rsh_d      = frame_wrap ? right_in : rsh_q;
    pos        = bit_cnt_d[4:0];
    word       = bit_cnt_d[5] ? rsh_d : lsh_d;
    // Slot pos 0 of a 32-bit word carries the other channel's LSB, from before this cycle's latch.
    prev_lsb   = bit_cnt_d[5] ? lsh_q[0] : rsh_q[0];
    shamt      = '0;
    bit_en     = 1'b0;
    use_prev   = 1'b0;
`ifdef I2S_AUDIO_TX_LJ_EN
    if ({1'b0, pos} < DW6) begin
      bit_en = 1'b1;
      shamt  = DW6 - 6'd1 - {1'b0, pos};
    end
`else
    if (pos != 5'd0 && {1'b0, pos} <= DW6) begin
      bit_en = 1'b1;
      shamt  = DW6 - {1'b0, pos};
    end else if (pos == 5'd0 && AUDIO_DW == SLOT_BITS) begin
      use_prev = 1'b1;
    end
`endif
    word_bit = |(word & (AUDIO_DW'(1) << shamt));
    data_d   = bit_en ? word_bit : (use_prev & prev_lsb);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= bit_cnt_t'(FRAME_BITS - 1);
      lrck_q    <= 1'b0;
      data_q    <= 1'b0;
      req_q     <= 1'b0;
      lsh_q     <= '0;
      rsh_q     <= '0;
    end else begin
      req_q <= fall_stb & frame_wrap;
      if (fall_stb) begin
        bit_cnt_q <= bit_cnt_d;
        lrck_q    <= bit_cnt_d[5];
        data_q    <= data_d;
        lsh_q     <= lsh_d;
        rsh_q     <= rsh_d;
      end
    end
  end

  assign sample_req = req_q;
  assign i2s_lrck   = lrck_q;
  assign i2s_data   = data_q;

endmodule
